// File: rtl/conv2_sched_pkg.sv
// Shared types and default sizing for the conv2 3x3 filter sequencing controller.
package conv2_pkg;

  localparam int DEF_IMG_W    = 14;
  localparam int DEF_IMG_H    = 14;
  localparam int DEF_IN_CH    = 32;
  localparam int DEF_OUT_CH   = 64;
  localparam int DEF_PIPE_LAT = 12;
  localparam int DEF_CREDITS  = 8;

  localparam int OUT_W = DEF_IMG_W - 2;
  localparam int OUT_H = DEF_IMG_H - 2;

  // Counter/field width that stays at least one bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [cw(DEF_OUT_CH)-1:0] oc;
    logic                      first;
    logic                      last;
  } tag_t;

endpackage

// File: rtl/conv2_sched_if.sv
// Window/filter/partial-sum signal bundle between line buffer, filter and conv2_sched.
interface conv2_sched_if import conv2_pkg::*; #(
  parameter int IN_CH  = DEF_IN_CH,
  parameter int OUT_CH = DEF_OUT_CH
);
  localparam int WA_W = cw(OUT_CH * IN_CH);
  localparam int OC_W = cw(OUT_CH);

  logic            win_valid;
  logic            win_ready;
  logic            filt_valid;
  logic [WA_W-1:0] weight_addr;
  logic            bias_zero;
  logic            credit_ret;
  logic            psum_valid;
  logic            psum_first;
  logic            psum_last;
  logic [OC_W-1:0] psum_oc;

  modport master (
    output win_valid, credit_ret,
    input  win_ready, filt_valid, weight_addr, bias_zero,
           psum_valid, psum_first, psum_last, psum_oc
  );

  modport slave (
    input  win_valid, credit_ret,
    output win_ready, filt_valid, weight_addr, bias_zero,
           psum_valid, psum_first, psum_last, psum_oc
  );
endinterface

// File: rtl/conv2_sched_tag_pipe.sv
// Valid + tag delay line matching the filter latency; empty also accounts for this cycle's push.
module conv2_tag_pipe #(
  parameter int  LAT   = conv2_pkg::DEF_PIPE_LAT,
  parameter type TAG_T = conv2_pkg::tag_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  TAG_T tag_in,
  output logic out_v,
  output TAG_T out_tag,
  output logic empty
);

  logic [LAT-1:0] v;
  TAG_T           tags [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
    end else begin
      v[0] <= push;
      for (int unsigned i = 1; i < LAT; i++) v[i] <= v[i-1];
    end
  end

  // Tag payload needs no reset; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    tags[0] <= tag_in;
    for (int unsigned i = 1; i < LAT; i++) tags[i] <= tags[i-1];
  end

  assign out_v   = v[LAT-1];
  assign out_tag = tags[LAT-1];
  assign empty   = ~(|v) & ~push;

endmodule

// File: rtl/conv2_sched.sv
// conv2 sequencing controller: walks ic/col/row/oc, issues windows under accumulator credit, tags partial sums.
module conv2_sched import conv2_pkg::*; #(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int IN_CH    = DEF_IN_CH,
  parameter int OUT_CH   = DEF_OUT_CH,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int CREDITS  = DEF_CREDITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  conv2_sched_if.slave        bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int COLS  = IMG_W - 2;
  localparam int ROWS  = IMG_H - 2;
  localparam int IC_W  = cw(IN_CH);
  localparam int COL_W = cw(COLS);
  localparam int ROW_W = cw(ROWS);
  localparam int OC_W  = cw(OUT_CH);
  localparam int WA_W  = cw(OUT_CH * IN_CH);
  localparam int CR_W  = $clog2(CREDITS + 1);

  typedef struct packed {
    logic [OC_W-1:0] oc;
    logic            first;
    logic            last;
  } ptag_t;

  state_t state, state_nx;

  logic [IC_W-1:0]  ic;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [OC_W-1:0]  oc;
  logic [CR_W-1:0]  credits;

  logic  win_ready, issue, start_acc, last_issue;
  logic  ic_max, col_max, row_max, oc_max;
  logic  pipe_v, pipe_empty;
  ptag_t tag_in, tag_out;

  assign ic_max  = (ic  == IC_W'(IN_CH - 1));
  assign col_max = (col == COL_W'(COLS - 1));
  assign row_max = (row == ROW_W'(ROWS - 1));
  assign oc_max  = (oc  == OC_W'(OUT_CH - 1));

  assign issue      = bus.win_valid & win_ready;
  assign start_acc  = (state == S_IDLE) & start;
  assign last_issue = issue & ic_max & col_max & row_max & oc_max;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    win_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        win_ready = (credits != '0);
        busy      = 1'b1;
        if (last_issue) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Loop nest, innermost first: ic, col, row, oc.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      ic  <= '0;
      col <= '0;
      row <= '0;
      oc  <= '0;
    end else if (issue) begin
      if (!ic_max) begin
        ic <= ic + 1'b1;
      end else begin
        ic <= '0;
        if (!col_max) begin
          col <= col + 1'b1;
        end else begin
          col <= '0;
          if (!row_max) begin
            row <= row + 1'b1;
          end else begin
            row <= '0;
            oc  <= oc_max ? '0 : oc + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CR_W'(CREDITS);
      err     <= 1'b0;
    end else begin
      unique case ({issue, bus.credit_ret})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CR_W'(CREDITS)) err <= 1'b1;
          else                           credits <= credits + 1'b1;
        end
        default: credits <= credits;
      endcase
    end
  end

  assign tag_in.oc    = oc;
  assign tag_in.first = (ic == '0);
  assign tag_in.last  = ic_max;

  conv2_tag_pipe #(
    .LAT   (PIPE_LAT),
    .TAG_T (ptag_t)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .push    (issue),
    .tag_in  (tag_in),
    .out_v   (pipe_v),
    .out_tag (tag_out),
    .empty   (pipe_empty)
  );

  assign bus.win_ready   = win_ready;
  assign bus.filt_valid  = issue;
  assign bus.weight_addr = WA_W'(oc) * WA_W'(IN_CH) + WA_W'(ic);
  assign bus.bias_zero   = (ic != '0);
  assign bus.psum_valid  = pipe_v;
  assign bus.psum_first  = tag_out.first;
  assign bus.psum_last   = tag_out.last;
  assign bus.psum_oc     = tag_out.oc;

endmodule

// File: tb/tb_conv2_sched.sv
// Scoreboard bench for conv2_sched: issue-side tag model vs. delayed partial-sum outputs.
module tb_conv2_sched;

  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int ICH = 2;
  localparam int OCH = 2;
  localparam int LAT = 4;
  localparam int CR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic win_valid = 1'b0;
  logic cr_force = 1'b0;
  logic echo_en = 1'b0;
  logic credit_ret;
  logic busy, done, err;

  conv2_sched_if #(.IN_CH(ICH), .OUT_CH(OCH)) bus ();

  assign bus.win_valid  = win_valid;
  assign credit_ret     = echo_en ? bus.psum_valid : cr_force;
  assign bus.credit_ret = credit_ret;

  conv2_sched #(
    .IMG_W    (IW),
    .IMG_H    (IH),
    .IN_CH    (ICH),
    .OUT_CH   (OCH),
    .PIPE_LAT (LAT),
    .CREDITS  (CR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int oc;
    bit first;
    bit last;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int issue_cnt = 0;
  int psum_cnt = 0;
  int done_cnt = 0;
  int m_ic = 0, m_col = 0, m_row = 0, m_oc = 0;
  int exp_wa [16] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3, 2, 3, 2, 3, 2, 3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (start && !busy && !done) begin
        m_ic = 0; m_col = 0; m_row = 0; m_oc = 0;
        issue_cnt = 0; psum_cnt = 0; done_cnt = 0;
      end
      check_eq("filt_valid", 32'(bus.filt_valid), 32'(win_valid & bus.win_ready));
      if (bus.filt_valid) begin
        if (issue_cnt < 16) check_eq("weight_addr", 32'(bus.weight_addr), exp_wa[issue_cnt]);
        check_eq("bias_zero", 32'(bus.bias_zero), 32'(m_ic != 0));
        q.push_back('{cyc + LAT, m_oc, (m_ic == 0), (m_ic == ICH - 1)});
        issue_cnt++;
        m_ic++;
        if (m_ic == ICH) begin
          m_ic = 0; m_col++;
          if (m_col == IW - 2) begin
            m_col = 0; m_row++;
            if (m_row == IH - 2) begin
              m_row = 0; m_oc = (m_oc + 1) % OCH;
            end
          end
        end
      end
      if (bus.psum_valid) begin
        psum_cnt++;
        if (q.size() == 0) begin
          check_eq("psum_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check_eq("psum_latency", cyc, e.t);
          check_eq("psum_oc", 32'(bus.psum_oc), e.oc);
          check_eq("psum_first", 32'(bus.psum_first), 32'(e.first));
          check_eq("psum_last", 32'(bus.psum_last), 32'(e.last));
        end
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_at_done", 32'(busy), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic run_pass(input bit mid_start);
    int k;
    echo_en = 1'b1;
    cr_force = 1'b0;
    win_valid = 1'b1;
    start = 1'b1;
    sample();
    check_eq("busy_on_start", 32'(busy), 0);
    check_eq("ready_on_start", 32'(bus.win_ready), 0);
    step();
    start = 1'b0;
    sample();
    check_eq("busy_after_start", 32'(busy), 1);
    check_eq("ready_issue1", 32'(bus.win_ready), 1);
    step();
    sample();
    check_eq("ready_issue2", 32'(bus.win_ready), 1);
    step();
    sample();
    check_eq("ready_credit_limit", 32'(bus.win_ready), 0);
    k = 0;
    while (!done && k < 300) begin
      step();
      start = (mid_start && k == 5) ? 1'b1 : 1'b0;
      sample();
      k++;
    end
    if (k >= 300) check_eq("done_timeout", 0, 1);
    start = 1'b0;
    repeat (8) begin
      step();
      sample();
    end
    check_eq("pass_issues", issue_cnt, 16);
    check_eq("pass_psums", psum_cnt, 16);
    check_eq("pass_done_once", done_cnt, 1);
    check_eq("pass_queue_empty", 32'(q.size()), 0);
    check_eq("pass_busy_end", 32'(busy), 0);
    check_eq("pass_err", 32'(err), 0);
    win_valid = 1'b0;
    echo_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    sample();
    check_eq("rst_win_ready", 32'(bus.win_ready), 0);
    check_eq("rst_filt_valid", 32'(bus.filt_valid), 0);
    check_eq("rst_psum_valid", 32'(bus.psum_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);

    step();
    run_pass(1'b0);

    // Credit starvation: no returns, two issues then stall.
    step();
    win_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    sample();
    check_eq("starve_issues", issue_cnt, 2);
    check_eq("starve_ready", 32'(bus.win_ready), 0);
    step();
    cr_force = 1'b1;
    sample();
    check_eq("ready_during_ret", 32'(bus.win_ready), 0);
    step();
    cr_force = 1'b0;
    sample();
    check_eq("ready_after_ret", 32'(bus.win_ready), 1);
    check_eq("filt_after_ret", 32'(bus.filt_valid), 1);
    step();
    sample();
    check_eq("ready_after_one", 32'(bus.win_ready), 0);
    check_eq("starve_issues_3", issue_cnt, 3);

    // Simultaneous issue and return at credits==1.
    step();
    win_valid = 1'b0;
    cr_force = 1'b1;
    step();
    win_valid = 1'b1;
    cr_force = 1'b1;
    sample();
    check_eq("simul_ready", 32'(bus.win_ready), 1);
    step();
    cr_force = 1'b0;
    sample();
    check_eq("simul_ready_next", 32'(bus.win_ready), 1);
    step();
    sample();
    check_eq("simul_ready_drained", 32'(bus.win_ready), 0);
    check_eq("simul_issues", issue_cnt, 5);
    check_eq("simul_err", 32'(err), 0);

    // Reset mid-run with three tokens in flight.
    step();
    win_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    start = 1'b1;
    win_valid = 1'b1;
    step();
    start = 1'b0;
    cr_force = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    cr_force = 1'b0;
    win_valid = 1'b0;
    sample();
    check_eq("inflight_issues", issue_cnt, 3);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check_eq("psum_after_rst", 32'(bus.psum_valid), 0);
      check_eq("busy_after_rst", 32'(busy), 0);
      step();
    end

    run_pass(1'b1);

    // Credit return at full credits is an error that persists until reset.
    step();
    cr_force = 1'b1;
    step();
    cr_force = 1'b0;
    sample();
    check_eq("err_set", 32'(err), 1);
    repeat (5) step();
    sample();
    check_eq("err_sticky", 32'(err), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check_eq("err_cleared", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
